// File: rtl/svs_stream_fifo.sv
// ---------------------------------------------------------------------------
// svs_stream_fifo
//
// First-word-fall-through stream FIFO with valid/ready handshakes on both
// sides, occupancy reporting, almost-full/almost-empty flags, a synchronous
// flush and a sticky upstream protocol-violation flag.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   flush        synchronous clear of contents (priority over push/pop)
//   s_valid      upstream word valid
//   s_ready      FIFO can accept a word (count != DEPTH)
//   s_data       upstream payload
//   m_valid      head word valid (count != 0)
//   m_ready      downstream accepts head word
//   m_data       head payload, forced to 0 while m_valid is low
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   proto_err    sticky: upstream dropped or changed a stalled word
//   clr_err      synchronous clear of proto_err (a new violation wins)
// ---------------------------------------------------------------------------
module svs_stream_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     proto_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is intentionally left unreset; m_data masking keeps outputs clean.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;

  logic              stall_reg;
  logic [DATA_W-1:0] stall_data_reg;
  logic              proto_err_reg;

  logic              push;
  logic              pop;
  logic              stall_now;
  logic              violation;

  // Status flags all derive from the registered count, so they change
  // together one edge after the handshake that moved them.
  assign s_ready      = (count_reg != CW'(DEPTH));
  assign m_valid      = (count_reg != '0);
  assign m_data       = m_valid ? mem[rd_ptr_reg] : '0;
  assign count        = count_reg;
  assign almost_full  = (count_reg >= CW'(AF_THRESH));
  assign almost_empty = (count_reg <= CW'(AE_THRESH));
  assign proto_err    = proto_err_reg;

  // Flush discards any handshake occurring in the same cycle.
  assign push = s_valid && s_ready && !flush;
  assign pop  = m_valid && m_ready && !flush;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  // A stalled upstream word must be held stable until accepted. Compare the
  // current cycle against what was offered during the previous stall.
  assign stall_now = s_valid && !s_ready && !flush;
  assign violation = stall_reg && (!s_valid || (s_data != stall_data_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg      <= 1'b0;
      stall_data_reg <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      stall_reg      <= stall_now;
      stall_data_reg <= s_data;
      if (violation)    proto_err_reg <= 1'b1;
      else if (clr_err) proto_err_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svs_stream_fifo.sv
module tb_svs_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [4:0]        count;
  logic              almost_full;
  logic              almost_empty;
  logic              proto_err;
  logic              clr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  svs_stream_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .proto_err(proto_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Preload 5 words, then pull reset in the middle of a cycle.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h70 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    total_cnt++;
    if (count !== 5'd5) $display("FAIL reset_preload_count: got %0d expected 5", count);
    else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count);
    else pass_cnt++;
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid);
    else pass_cnt++;
    total_cnt++;
    if (m_data !== 8'h00) $display("FAIL reset_m_data: got %0h expected 0", m_data);
    else pass_cnt++;
    total_cnt++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", s_ready);
    else pass_cnt++;
    total_cnt++;
    if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty: got %b expected 1", almost_empty);
    else pass_cnt++;
    total_cnt++;
    if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b expected 0", almost_full);
    else pass_cnt++;
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b expected 0", proto_err);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    $display("reset: asserted mid-cycle with 5 words held");
  endtask

  task automatic test_fill_drain();
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      $display("push %0h count=%0d", i, count);
      total_cnt++;
      if (count !== 5'(i)) $display("FAIL fill_count: got %0d expected %0d", count, i);
      else pass_cnt++;
      total_cnt++;
      if (almost_full !== (i >= 14)) $display("FAIL fill_almost_full: got %b expected %b at %0d", almost_full, (i >= 14), i);
      else pass_cnt++;
      total_cnt++;
      if (s_ready !== (i != 16)) $display("FAIL fill_s_ready: got %b expected %b at %0d", s_ready, (i != 16), i);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total_cnt++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) $display("FAIL drain_data: got v=%b d=%0h expected v=1 d=%0h", m_valid, m_data, i);
      else pass_cnt++;
      step();
      $display("pop %0h count=%0d", i, count);
      total_cnt++;
      if (count !== 5'(16 - i)) $display("FAIL drain_count: got %0d expected %0d", count, 16 - i);
      else pass_cnt++;
      total_cnt++;
      if (almost_empty !== ((16 - i) <= 2)) $display("FAIL drain_almost_empty: got %b expected %b", almost_empty, ((16 - i) <= 2));
      else pass_cnt++;
    end
    m_ready = 1'b0;
    total_cnt++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) $display("FAIL drain_empty: got v=%b d=%0h expected v=0 d=0", m_valid, m_data);
    else pass_cnt++;
  endtask

  task automatic test_wraparound();
    int errs = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h20 + 8'(i);
      step();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_data = 8'h25 + 8'(k);
      if (m_data !== 8'h20 + 8'(k)) errs++;
      step();
      if (count !== 5'd5) errs++;
    end
    s_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (m_valid !== 1'b1 || m_data !== 8'h48 + 8'(j)) errs++;
      step();
    end
    m_ready = 1'b0;
    $display("wraparound: 45 words streamed through");
    total_cnt++;
    if (errs != 0) $display("FAIL wrap_stream: got %0d bad cycles expected 0", errs);
    else pass_cnt++;
    total_cnt++;
    if (count !== 5'd0) $display("FAIL wrap_final_count: got %0d expected 0", count);
    else pass_cnt++;
  endtask

  task automatic test_full_pop();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h30 + 8'(i);
      step();
    end
    s_data  = 8'h99;
    m_ready = 1'b1;
    total_cnt++;
    if (s_ready !== 1'b0) $display("FAIL fullpop_s_ready_before: got %b expected 0", s_ready);
    else pass_cnt++;
    step();
    m_ready = 1'b0;
    total_cnt++;
    if (count !== 5'd15 || s_ready !== 1'b1) $display("FAIL fullpop_after_pop: got count=%0d rdy=%b expected 15 1", count, s_ready);
    else pass_cnt++;
    step();
    s_valid = 1'b0;
    total_cnt++;
    if (count !== 5'd16) $display("FAIL fullpop_accept: got %0d expected 16", count);
    else pass_cnt++;
    m_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      total_cnt++;
      if (m_data !== ((j < 15) ? 8'h31 + 8'(j) : 8'h99)) $display("FAIL fullpop_order: got %0h expected %0h", m_data, ((j < 15) ? 8'h31 + 8'(j) : 8'h99));
      else pass_cnt++;
      step();
    end
    m_ready = 1'b0;
    $display("full_pop: word 99 accepted after pop freed a slot");
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h40 + 8'(i);
      step();
    end
    flush   = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    total_cnt++;
    if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00) $display("FAIL flush_clear: got c=%0d v=%b d=%0h expected 0 0 0", count, m_valid, m_data);
    else pass_cnt++;
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_valid = 1'b0;
    total_cnt++;
    if (count !== 5'd1 || m_data !== 8'h55) $display("FAIL flush_next_word: got c=%0d d=%0h expected 1 55", count, m_data);
    else pass_cnt++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    $display("flush: 7 words and concurrent push discarded");
  endtask

  task automatic test_proto();
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL proto_initial: got %b expected 0", proto_err);
    else pass_cnt++;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h60 + 8'(i);
      step();
    end
    s_data = 8'hAA;
    step();
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL proto_first_stall: got %b expected 0", proto_err);
    else pass_cnt++;
    s_data = 8'hBB;
    step();
    total_cnt++;
    if (proto_err !== 1'b1) $display("FAIL proto_set: got %b expected 1", proto_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (proto_err !== 1'b1) $display("FAIL proto_sticky: got %b expected 1", proto_err);
    else pass_cnt++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    total_cnt++;
    if (proto_err !== 1'b1 || count !== 5'd16) $display("FAIL proto_hold: got e=%b c=%0d expected 1 16", proto_err, count);
    else pass_cnt++;
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL proto_clear: got %b expected 0", proto_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL proto_stay_clear: got %b expected 0", proto_err);
    else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    $display("proto: AA->BB change flagged and cleared");
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    clr_err = 1'b0;
    #2;
    total_cnt++;
    if (count !== 5'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || almost_empty !== 1'b1)
      $display("FAIL power_on_reset: got c=%0d v=%b r=%b ae=%b expected 0 0 1 1", count, m_valid, s_ready, almost_empty);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    test_reset();
    test_fill_drain();
    test_wraparound();
    test_full_pop();
    test_flush();
    test_proto();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/svs_stream_fifo.md
Name: svs_stream_fifo

Overview:
- Parametrised first-word-fall-through (FWFT) stream FIFO with valid/ready handshakes on both sides.
- Adds occupancy reporting, almost-full/almost-empty thresholds, synchronous flush, and a sticky upstream protocol-violation flag.
- Sits between a producer and a consumer in the same clock domain; standard elastic buffer for datapath blocks.

Parameters:
- DATA_W, 8: payload width in bits.
- DEPTH, 16: number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DATA_W  upstream payload.
- m_valid  out  1  head word valid.
- m_ready  in  1  downstream accepts head word.
- m_data  out  DATA_W  head payload.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- proto_err  out  1  sticky: upstream handshake violation.
- clr_err  in  1  synchronous clear of proto_err.

Behaviour:
- Reset (rst low, asynchronous):
  - Write pointer, read pointer, count and proto_err go to 0.
  - Outputs immediately: s_ready=1, m_valid=0, m_data=0, count=0, almost_full=0 (given AF_THRESH>=1), almost_empty=1.
  - Storage array is not reset.
- Push: s_valid && s_ready at a rising edge.
  - mem[wr_ptr] <= s_data; wr_ptr increments modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop: m_valid && m_ready at a rising edge. rd_ptr increments modulo DEPTH.
- count update:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Neither: unchanged.
- s_ready = (count != DEPTH), combinational from registered count.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - s_ready rises the cycle after the pop.
- m_valid = (count != 0).
- m_data = m_valid ? mem[rd_ptr] : 0. Never X after reset.
- Latency: a word pushed at edge N is visible on m_valid/m_data after edge N, so it can be popped at edge N+1. There is no bypass path when empty.
- almost_full and almost_empty are combinational from registered count and change in the same cycle as count.
- flush:
  - At the edge where flush=1: pointers and count go to 0.
  - Any push or pop in that cycle is discarded; flush has priority.
  - proto_err is unaffected.
- Protocol check (registered):
  - Record stall = s_valid && !s_ready and the stalled s_data each cycle.
  - If the previous cycle stalled and the current cycle has s_valid=0, or s_data differs from the stalled value, set proto_err=1 at the next edge.
  - A stall in a cycle where flush=1 is not recorded.
- proto_err is sticky until clr_err=1. If clr_err and a new violation occur in the same cycle, set wins.
- Arithmetic: count never exceeds DEPTH and never underflows; pops are only possible when m_valid=1.

Test Plan:
- Reset check: rst low mid-cycle with count=5 -> immediately count=0, m_valid=0, m_data=0, s_ready=1, almost_empty=1, proto_err=0.
- Fill and drain (DEPTH=16, AF_THRESH=14, m_ready=0):
  - Push 0x01..0x10 -> almost_full=1 after the 14th push; count=16 and s_ready=0 after the 16th.
  - Then m_ready=1 -> pops 0x01..0x10 in order; almost_empty=1 once count<=2; m_valid=0 after the last pop.
- Wrap-around streaming: preload 5 words, then 40 cycles of continuous push and pop -> count stays 5, pointers wrap twice, output sequence equals input sequence.
- Full with simultaneous pop: count=16, s_valid=1, m_ready=1 -> the word is not accepted that cycle; count=15, s_ready=1 next cycle; the word is accepted the following edge.
- Flush priority: count=7, flush=1 with s_valid=1 and m_ready=1 -> next cycle count=0, m_valid=0, m_data=0; the pushed word never appears.
- Protocol violation: at full, s_valid=1 with s_data=0xAA, then s_data=0xBB next cycle -> proto_err=1 after that edge and it stays set; clr_err=1 for one cycle -> proto_err=0.
